// File: rtl/conv_mac_engine.sv
// -----------------------------------------------------------------------------
// conv_mac_engine
//
// Sequential convolution MAC: computes the dot product of an N x N window of
// unsigned pixels with an N x N signed kernel, one tap per clock, using a
// single multiply-accumulate unit. N is chosen per operation (1..MAX_N).
//
// Optional feature macro: CONV_SAT_EN
//   defined   -> result_out is the accumulator clamped to the signed OUT_W
//                range; sat flags that clamping happened.
//   undefined -> result_out is the low OUT_W bits of the accumulator
//                (wrap-around); sat is constant 0.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   request an operation (sampled in IDLE and DONE)
//   pixel      in   MAX_N*MAX_N unsigned pixels, element (r,c) at
//                   [(r*MAX_N+c)*DATA_W +: DATA_W]
//   kernel     in   signed kernel, same packing as pixel
//   dim        in   window dimension N (legal 1..MAX_N)
//   busy       out  high while taps are being accumulated
//   done       out  one-cycle completion pulse
//   result_out out  signed result, held until the next completion
//   err        out  last accepted request had an illegal dim
//   sat        out  last result was clamped
// -----------------------------------------------------------------------------
module conv_mac_engine #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 5,
  parameter int ACC_W  = 22,
  parameter int OUT_W  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]     pixel,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]     kernel,
  input  logic [2:0]                        dim,
  output logic                              busy,
  output logic                              done,
  output logic [OUT_W-1:0]                  result_out,
  output logic                              err,
  output logic                              sat
);

  localparam int TAPS   = MAX_N * MAX_N;
  localparam int PW     = TAPS * DATA_W;
  localparam int IDX_W  = $clog2(PW);
  localparam int PROD_W = 2 * DATA_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [PW-1:0]             pix_q, pix_d;
  logic [PW-1:0]             ker_q, ker_d;
  logic [2:0]                n_q, n_d;
  logic [2:0]                row_q, row_d;
  logic [2:0]                col_q, col_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]          res_q, res_d;
  logic                      err_q, err_d;
  logic                      sat_q, sat_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [IDX_W-1:0]          base_s;
  logic [DATA_W-1:0]         pix_tap_s;
  logic [DATA_W-1:0]         ker_tap_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]   acc_sum_s;
  logic [OUT_W:0]            conv_s;
  logic                      dim_ok_s;
  logic                      last_tap_s;
  logic                      last_col_s;

  // Accumulator to output conversion: returns {sat_flag, value}.
  function automatic logic [OUT_W:0] convert(input logic signed [ACC_W-1:0] a);
`ifdef CONV_SAT_EN
    logic [ACC_W-OUT_W:0] hi;
    hi = a[ACC_W-1:OUT_W-1];
    // In range when every bit above the OUT_W sign bit repeats the sign.
    if ((&hi) || !(|hi)) begin
      convert = {1'b0, a[OUT_W-1:0]};
    end else if (a[ACC_W-1]) begin
      convert = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      convert = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end
`else
    convert = {1'b0, a[OUT_W-1:0]};
`endif
  endfunction

  // Tap selection, multiply and accumulate datapath.
  always_comb begin
    base_s     = IDX_W'((int'(row_q) * MAX_N + int'(col_q)) * DATA_W);
    pix_tap_s  = pix_q[base_s +: DATA_W];
    ker_tap_s  = ker_q[base_s +: DATA_W];
    // Pixel is zero-extended to make it a non-negative signed operand.
    prod_s     = PROD_W'($signed({1'b0, pix_tap_s})) * PROD_W'($signed(ker_tap_s));
    acc_sum_s  = acc_q + ACC_W'(prod_s);
    conv_s     = convert(acc_sum_s);
    dim_ok_s   = (dim != 3'd0) && (int'(dim) <= MAX_N);
    last_col_s = (col_q == (n_q - 3'd1));
    last_tap_s = last_col_s && (row_q == (n_q - 3'd1));
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    ker_d   = ker_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    res_d   = res_q;
    err_d   = err_q;
    sat_d   = sat_q;
    case (state_q)
      // DONE accepts a new start exactly like IDLE, for back-to-back use.
      S_IDLE, S_DONE: begin
        if (start) begin
          pix_d = pixel;
          ker_d = kernel;
          n_d   = dim;
          acc_d = '0;
          row_d = 3'd0;
          col_d = 3'd0;
          if (dim_ok_s) begin
            state_d = S_MAC;
          end else begin
            // Illegal dimension completes immediately with an error result.
            state_d = S_DONE;
            err_d   = 1'b1;
            res_d   = '0;
            sat_d   = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        acc_d = acc_sum_s;
        if (last_tap_s) begin
          state_d = S_DONE;
          res_d   = conv_s[OUT_W-1:0];
          sat_d   = conv_s[OUT_W];
          err_d   = 1'b0;
        end else if (last_col_s) begin
          col_d = 3'd0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_MAC);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      ker_q   <= '0;
      n_q     <= 3'd0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      acc_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      ker_q   <= ker_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result_out = res_q;
  assign err        = err_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// -----------------------------------------------------------------------------
// tb_conv_mac_engine
//
// Self-checking bench for conv_mac_engine. A transaction-level reference
// (dot product with plain integers, plus a countdown of remaining edges)
// predicts every output each cycle; directed cases pin the reference with
// hand-computed literal values, and a randomized phase exercises the rest.
// -----------------------------------------------------------------------------
module tb_conv_mac_engine;

  localparam int DATA_W = 8;
  localparam int MAX_N  = 5;
  localparam int ACC_W  = 22;
  localparam int OUT_W  = 16;
  localparam int NT     = MAX_N * MAX_N;
  localparam int PW     = NT * DATA_W;

  logic              clk;
  logic              reset;
  logic              start;
  logic [PW-1:0]     pixel;
  logic [PW-1:0]     kernel;
  logic [2:0]        dim;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  result_out;
  logic              err;
  logic              sat;

  conv_mac_engine #(
    .DATA_W(DATA_W), .MAX_N(MAX_N), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pixel(pixel), .kernel(kernel),
    .dim(dim), .busy(busy), .done(done), .result_out(result_out),
    .err(err), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state.
  int               m_cnt = 0;     // edges left until the result appears
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  logic             m_err  = 1'b0;
  logic             m_sat  = 1'b0;
  logic [OUT_W-1:0] m_res  = '0;
  logic [OUT_W-1:0] p_res  = '0;
  logic             p_sat  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Dot product of the N x N window, then output conversion.
  function automatic void compute(input logic [PW-1:0] p, input logic [PW-1:0] k,
                                  input int n, output logic [OUT_W-1:0] r,
                                  output logic s);
    int sum;
    int pv;
    int kv;
    logic [DATA_W-1:0] pb;
    logic [DATA_W-1:0] kb;
    sum = 0;
    for (int rr = 0; rr < n; rr++) begin
      for (int cc = 0; cc < n; cc++) begin
        pb  = p[(rr * MAX_N + cc) * DATA_W +: DATA_W];
        kb  = k[(rr * MAX_N + cc) * DATA_W +: DATA_W];
        pv  = int'(pb);
        kv  = int'($signed(kb));
        sum = sum + pv * kv;
      end
    end
`ifdef CONV_SAT_EN
    if (sum > 32767) begin
      r = 16'h7FFF; s = 1'b1;
    end else if (sum < -32768) begin
      r = 16'h8000; s = 1'b1;
    end else begin
      r = sum[15:0]; s = 1'b0;
    end
`else
    r = sum[15:0];
    s = 1'b0;
`endif
  endfunction

  // Advance the model over the coming edge, take the edge, compare outputs.
  task automatic step();
    int n;
    if (reset) begin
      m_cnt = 0; m_busy = 1'b0; m_done = 1'b0;
      m_res = '0; m_err = 1'b0; m_sat = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      m_busy = (m_cnt > 0);
      m_done = (m_cnt == 0);
      if (m_cnt == 0) begin
        m_res = p_res; m_sat = p_sat; m_err = 1'b0;
      end
    end else if (start) begin
      n = int'(dim);
      if (n >= 1 && n <= MAX_N) begin
        compute(pixel, kernel, n, p_res, p_sat);
        m_cnt  = n * n;
        m_busy = 1'b1;
        m_done = 1'b0;
      end else begin
        m_busy = 1'b0; m_done = 1'b1;
        m_err  = 1'b1; m_res  = '0; m_sat = 1'b0;
      end
    end else begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("result_out", {16'd0, result_out}, {16'd0, m_res});
    check("err", {31'd0, err}, {31'd0, m_err});
    check("sat", {31'd0, sat}, {31'd0, m_sat});
  endtask

  // Issue one request and wait (bounded) for its done pulse.
  task automatic run_op(input logic [2:0] d, input logic [PW-1:0] p,
                        input logic [PW-1:0] k, output int lat);
    start = 1'b1; dim = d; pixel = p; kernel = k;
    step();
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [PW-1:0] fill(input logic [DATA_W-1:0] b);
    logic [PW-1:0] v;
    for (int i = 0; i < NT; i++) v[i * DATA_W +: DATA_W] = b;
    return v;
  endfunction

  function automatic logic [PW-1:0] rand_vec();
    logic [PW-1:0] v;
    for (int i = 0; i < NT; i++) v[i * DATA_W +: DATA_W] = DATA_W'($urandom_range(255, 0));
    return v;
  endfunction

  logic [PW-1:0] pv;
  logic [PW-1:0] kv;
  int            lat;
  int            pulses;
  int            last_done;

  initial begin
    reset = 1'b1; start = 1'b0; dim = 3'd0; pixel = '0; kernel = '0;
    step();
    step();
    check("reset_result", {16'd0, result_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    step();

    // N=2, pixels 10, kernel 1 -> 40 after 5 cycles.
    run_op(3'd2, fill(8'd10), fill(8'd1), lat);
    check("n2_latency", lat, 32'd5);
    check("n2_result", {16'd0, result_out}, 32'd40);
    check("n2_err", {31'd0, err}, 32'd0);
    step();

    // N=3, 255 * -128 * 9 = -293760.
    run_op(3'd3, fill(8'hFF), fill(8'h80), lat);
    check("n3_latency", lat, 32'd10);
`ifdef CONV_SAT_EN
    check("n3_sat_result", {16'd0, result_out}, 32'h8000);
    check("n3_sat_flag", {31'd0, sat}, 32'd1);
`else
    check("n3_wrap_result", {16'd0, result_out}, 32'h8480);
    check("n3_wrap_flag", {31'd0, sat}, 32'd0);
`endif
    step();

    // Identity kernel; everything outside the 3x3 window is 0xFF.
    pv = fill(8'hFF);
    pv[6 * DATA_W +: DATA_W] = 8'd77;
    kv = fill(8'hFF);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) kv[(r * MAX_N + c) * DATA_W +: DATA_W] = 8'd0;
    kv[6 * DATA_W +: DATA_W] = 8'd1;
    run_op(3'd3, pv, kv, lat);
    check("ident_result", {16'd0, result_out}, 32'd77);
    step();

    // Illegal dims complete in one cycle with err set.
    run_op(3'd0, fill(8'd3), fill(8'd3), lat);
    check("dim0_latency", lat, 32'd1);
    check("dim0_err", {31'd0, err}, 32'd1);
    check("dim0_result", {16'd0, result_out}, 32'd0);
    step();
    run_op(3'd6, fill(8'd3), fill(8'd3), lat);
    check("dim6_latency", lat, 32'd1);
    check("dim6_err", {31'd0, err}, 32'd1);
    step();
    run_op(3'd1, fill(8'd3), fill(8'd3), lat);
    check("legal_clears_err", {31'd0, err}, 32'd0);
    check("n1_result", {16'd0, result_out}, 32'd9);
    check("n1_latency", lat, 32'd2);
    step();

    // N=5 in progress: a stray start is ignored, then reset aborts.
    start = 1'b1; dim = 3'd5; pixel = rand_vec(); kernel = rand_vec();
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pixel = rand_vec(); kernel = rand_vec();
      step();
    end
    start = 1'b1; dim = 3'd1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {16'd0, result_out}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 32'd0);

    // Start held high, N=2, all ones: result 4 every 5 cycles.
    start = 1'b1; dim = 3'd2; pixel = fill(8'd1); kernel = fill(8'd1);
    pulses = 0;
    last_done = -1;
    for (int i = 0; i < 22; i++) begin
      step();
      if (done === 1'b1) begin
        pulses++;
        check("b2b_result", {16'd0, result_out}, 32'd4);
        if (last_done >= 0) check("b2b_period", cyc - last_done, 32'd5);
        last_done = cyc;
      end
    end
    check("b2b_count", pulses, 32'd4);
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic with operand churn and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(199, 0) == 0);
      start = ($urandom_range(2, 0) == 0);
      if ($urandom_range(7, 0) == 0) dim = 3'($urandom_range(7, 0));
      else dim = 3'($urandom_range(MAX_N, 1));
      pixel  = rand_vec();
      kernel = rand_vec();
      step();
    end
    reset = 1'b0;
    start = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
